// File: rtl/ssram_pkg.sv
// ssram_pkg: shared FSM state type, default read-corruption mask and clog2 helper for the replica-bitline SSRAM model
package ssram_pkg;
    typedef enum logic [1:0] {IDLE, DISC, SENSE} state_t;
    localparam logic [31:0] ERR_MASK_DEF = 32'h00030010;
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/ssram_array.sv
// ssram_array: data array (no reset) plus per-row weakness table (sync clear on rst); sync writes, combinational reads at addr
module ssram_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int TBL_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    input  logic              tbl_we,
    input  logic [TBL_W-1:0]  tbl_d,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rdata,
    output logic [TBL_W-1:0]  rtbl
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [TBL_W-1:0]  tbl [2**ADDR_W];
    assign rdata = mem[addr];
    assign rtbl  = tbl[addr];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) tbl[i] <= '0;
        end else if (tbl_we) begin
            tbl[addr] <= tbl_d;
        end
    end
endmodule

// File: rtl/ssram_rbl_model.sv
// ssram_rbl_model: replica-bitline SSRAM read/write model with weakness-driven discharge, optional retry passes and READY/QVALID handshake
module ssram_rbl_model
    import ssram_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 8,
    parameter int                TBL_W     = 5,
    parameter int                SENSE_CYC = 6,
    parameter int                MAX_RETRY = 3,
    parameter logic [DATA_W-1:0] ERR_MASK  = ERR_MASK_DEF
) (
    input  logic                             CLK,
    input  logic                             rst,
    input  logic                             CEN,
    input  logic                             WEN,
    input  logic                             MODE,
    input  logic [ADDR_W-1:0]                BRS,
    input  logic [DATA_W-1:0]                D,
    input  logic [TBL_W-1:0]                 EN,
    input  logic                             TBL_WE,
    input  logic [TBL_W-1:0]                 TBL_D,
    output logic                             READY,
    output logic [DATA_W-1:0]                Q,
    output logic                             QVALID,
    output logic                             FLAG,
    output logic [clog2(MAX_RETRY+1)-1:0]    RETRY_CNT
);
    localparam int SW = clog2(SENSE_CYC);
    localparam int RW = clog2(MAX_RETRY + 1);
    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] a;
    logic [TBL_W-1:0]  cnt;
    logic [TBL_W-1:0]  rem;
    logic [TBL_W-1:0]  rtbl;
    logic [SW-1:0]     scnt;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rdata;
    logic              idle_req;
    logic              abort;
    assign READY    = state == IDLE;
    assign idle_req = READY && !rst && !CEN;
    assign abort    = CEN || !WEN;
    assign a        = READY ? BRS : addr_q;
    ssram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TBL_W(TBL_W)) u_array (
        .clk    (CLK),
        .rst    (rst),
        .we     (idle_req && !WEN),
        .d      (D),
        .tbl_we (idle_req && TBL_WE),
        .tbl_d  (TBL_D),
        .addr   (a),
        .rdata  (rdata),
        .rtbl   (rtbl)
    );
    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            cnt       <= '0;
            rem       <= '0;
            scnt      <= '0;
            data_q    <= '0;
            Q         <= '0;
            QVALID    <= 1'b0;
            FLAG      <= 1'b0;
            RETRY_CNT <= '0;
        end else begin
            QVALID <= 1'b0;
            if (!READY && abort) begin
                state     <= IDLE;
                cnt       <= '0;
                rem       <= '0;
                scnt      <= '0;
                FLAG      <= 1'b0;
                RETRY_CNT <= '0;
            end else begin
                case (state)
                    IDLE: if (!CEN && WEN) begin
                        addr_q    <= BRS;
                        cnt       <= rtbl;
                        rem       <= EN;
                        FLAG      <= 1'b0;
                        RETRY_CNT <= '0;
                        state     <= DISC;
                    end
                    DISC: if (rem != '0) begin
                        rem <= rem - 1'b1;
                        cnt <= (cnt != '0) ? cnt - 1'b1 : cnt;
                    end else begin
                        state  <= SENSE;
                        scnt   <= SW'(SENSE_CYC - 1);
                        data_q <= (cnt == '0) ? rdata : rdata ^ ERR_MASK;
                    end
                    SENSE: if (scnt != '0) begin
                        scnt <= scnt - 1'b1;
                    end else if (cnt != '0 && MODE && RETRY_CNT != RW'(MAX_RETRY)) begin
                        // cnt deliberately carries over so each pass further drains the weak row
                        RETRY_CNT <= RETRY_CNT + 1'b1;
                        rem       <= EN;
                        state     <= DISC;
                    end else begin
                        Q      <= data_q;
                        QVALID <= 1'b1;
                        FLAG   <= cnt != '0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/ssram_rbl_model.md
Name: ssram_rbl_model

Overview:
- Parametrised, single-clock behavioural model of the replica-bitline SSRAM macro.
- Used for simulation only; the synthesis flow treats it as a black box.
- Models per-row bitline weakness with a programmable weakness table and a configurable discharge window.
- Adds a retry mode that re-discharges weak rows before returning data, plus a READY/QVALID handshake toward the core-side memory controller.

Parameters:
- DATA_W, 32, word width.
- ADDR_W, 8, row address width (depth = 2**ADDR_W).
- TBL_W, 5, width of the per-row weakness count and of EN.
- SENSE_CYC, 6, sense-amp settle cycles (must be >= 1).
- MAX_RETRY, 3, maximum extra discharge passes per read in retry mode.
- ERR_MASK, 32'h00030010, XOR pattern applied to data read from a still-weak row.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- CEN  in  1  chip enable, active-low.
- WEN  in  1  write enable, active-low (1 = read).
- MODE  in  1  1 = retry mode enabled.
- BRS  in  ADDR_W  row address.
- D  in  DATA_W  write data.
- EN  in  TBL_W  discharge cycles per pass; sampled at accept and at each retry.
- TBL_WE  in  1  with CEN=0, writes TBL_D into the weakness table at BRS.
- TBL_D  in  TBL_W  weakness value.
- READY  out  1  high only in IDLE.
- Q  out  DATA_W  read data; holds until the next QVALID.
- QVALID  out  1  one-cycle pulse when Q is updated.
- FLAG  out  1  row was still weak when the read completed; valid with QVALID, held until the next accept.
- RETRY_CNT  out  log2(MAX_RETRY+1)  retries used by the last read.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; Q=0, QVALID=0, FLAG=0, RETRY_CNT=0, internal counters 0; all weakness-table entries 0; data array not reset (X until written). READY=1 while in IDLE, but requests are ignored while rst=1. Reset mid-read aborts the read with no QVALID.
- States: IDLE, DISC, SENSE.
- IDLE, write (CEN=0, WEN=0): mem[BRS]<=D at that edge; stay IDLE.
- IDLE, table write (CEN=0, TBL_WE=1): tbl[BRS]<=TBL_D. This is independent of WEN; combined with WEN=0, both arrays are written in the same edge.
- IDLE, read (CEN=0, WEN=1): this is the accept edge. Latch addr=BRS, cnt=tbl[BRS], rem=EN; clear FLAG and RETRY_CNT; go to DISC. If TBL_WE=1 in the same edge, the OLD table value is used and the table is updated.
- DISC:
  - rem!=0: rem--, and cnt-- saturating at 0.
  - rem==0: go to SENSE, scnt=SENSE_CYC-1; capture data = (cnt==0) ? mem[addr] : mem[addr]^ERR_MASK.
- SENSE:
  - scnt!=0: scnt--.
  - scnt==0 and cnt!=0 and MODE=1 and retries<MAX_RETRY: RETRY_CNT++, rem=EN, go to DISC. cnt is NOT reloaded. No QVALID.
  - Otherwise: Q<=captured data, QVALID=1 for one cycle, FLAG<=(cnt!=0), go to IDLE.
- Latency: with accept at edge k, QVALID is seen after edge k+(r+1)*(EN+SENSE_CYC+1), where r is the number of retries taken.
- Abort: CEN=1 or WEN=0 sampled in DISC or SENSE. Go to IDLE, clear counters and FLAG, no QVALID, Q unchanged. Any write request in that same cycle is ignored.
- Requests while READY=0 (other than the abort above) are ignored; writes are never queued.
- EN=0: DISC lasts one cycle; cnt is unchanged.
- Address, EN and MODE may change after accept. addr is latched; EN and MODE are re-sampled at each retry decision.

Decomposition:
- Shared package ssram_pkg: state enum (IDLE, DISC, SENSE), ERR_MASK default, and the function clog2 for the RETRY_CNT width.
- One sub-module, ssram_array:
  - Holds the data array and weakness table.
  - Synchronous write ports; combinational read of both at a given address.
  - Synchronous table clear on rst.
- The top level holds the FSM and counters.

Test Plan:
- Write then read, tbl=0: write D=32'hDEADBEEF @8'h10, then read with EN=2 and SENSE_CYC=6. Expect QVALID 9 edges after accept, Q=32'hDEADBEEF, FLAG=0.
- Weak row, no retry: tbl[8'h10]=5, EN=2, MODE=0. Expect Q=32'hDEADBEEF^32'h00030010=32'hDEAEBEFF, FLAG=1, RETRY_CNT=0, QVALID at edge 9.
- Retry recovers: tbl=5, EN=2, MODE=1. Passes leave cnt=3, 1, then 0. Expect RETRY_CNT=2, Q=32'hDEADBEEF, FLAG=0, QVALID at edge 27.
- Retry exhausted: tbl=31, EN=1, MODE=1, MAX_RETRY=3. Expect RETRY_CNT=3, FLAG=1, corrupted Q, QVALID at edge 32.
- Abort: raise CEN during SENSE. Expect return to IDLE the next edge, no QVALID, READY=1, Q unchanged. A subsequent read completes normally.
- Reset mid-read plus table clear: assert rst during DISC. Expect READY=1 and outputs zero. A read of a previously weak row then returns FLAG=0 (table cleared).
